// File: rtl/button_pkg.sv
// Shared constants and types for the pushbutton conditioning path.
// Bit indices match the parameter selector's up/down/next/set inputs.
package button_pkg;

    localparam int NUM_BTN   = 4;
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_NEXT  = 2;
    localparam int BTN_SET   = 3;

    // 10 ms debounce, 0.5 s hold-off and 0.1 s repeat period at 65 MHz.
    localparam int DEF_DEBOUNCE_CYCLES = 650000;
    localparam int DEF_HOLD_CYCLES     = 32500000;
    localparam int DEF_REPEAT_CYCLES   = 6500000;

    typedef enum logic [1:0] {
        RELEASED        = 2'd0,
        PRESS_PENDING   = 2'd1,
        HELD            = 2'd2,
        RELEASE_PENDING = 2'd3
    } chan_state_e;

    function automatic logic is_down(chan_state_e s);
        return (s == HELD) || (s == RELEASE_PENDING);
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Pushbutton pins in; debounced levels, edge/repeat strobes and channel FSM states out.
interface button_conditioner_if;

    logic [button_pkg::NUM_BTN-1:0]   btn_raw;
    logic [button_pkg::NUM_BTN-1:0]   btn_level;
    logic [button_pkg::NUM_BTN-1:0]   btn_press;
    logic [button_pkg::NUM_BTN-1:0]   btn_release;
    logic [button_pkg::NUM_BTN-1:0]   btn_repeat;
    logic [2*button_pkg::NUM_BTN-1:0] dbg_state;

    // No valid/ready pair here: btn_raw is level-sampled every clock, btn_level is a level,
    // and press/release/repeat are single-cycle strobes the consumer must take when they
    // appear (there is no back-pressure). dbg_state packs one chan_state_e per button.
    modport master (
        output btn_raw,
        input  btn_level, btn_press, btn_release, btn_repeat, dbg_state
    );

    modport slave (
        input  btn_raw,
        output btn_level, btn_press, btn_release, btn_repeat, dbg_state
    );

endinterface

// File: rtl/debounce_channel.sv
// One pushbutton: two-flop synchroniser, debounce FSM, registered edge strobes
// and a hold-to-repeat timer.
module debounce_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic        clk_65mhz,
    input  logic        rst,
    input  logic        raw_i,
    output logic        level_o,
    output logic        press_o,
    output logic        release_o,
    output logic        repeat_o,
    output chan_state_e state_o
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
    localparam int REP_W  = $clog2(REPEAT_CYCLES) + 1;

    localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    logic              s1_q, s2_q;
    chan_state_e       state_q, state_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              repeat_q, repeat_d;
    logic              differs, deb_done, stay_down;

    always_ff @(posedge clk_65mhz) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= raw_i;
            s2_q <= s1_q;
        end
    end

    // The count must already hold DEBOUNCE_CYCLES and the input still differ to toggle.
    assign differs  = (s2_q != level_q);
    assign deb_done = differs && (deb_cnt_q == DEB_MAX);

    always_ff @(posedge clk_65mhz) begin
        if (rst) begin
            state_q <= RELEASED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RELEASED:        if (s2_q) state_d = PRESS_PENDING;
            PRESS_PENDING:   if (!s2_q) state_d = RELEASED;
                             else if (deb_done) state_d = HELD;
            HELD:            if (!s2_q) state_d = RELEASE_PENDING;
            RELEASE_PENDING: if (s2_q) state_d = HELD;
                             else if (deb_done) state_d = RELEASED;
            default:         state_d = RELEASED;
        endcase
    end

    always_comb begin
        level_d    = is_down(state_d);
        press_d    = (state_q == PRESS_PENDING) && (state_d == HELD);
        release_d  = (state_q == RELEASE_PENDING) && (state_d == RELEASED);
        deb_cnt_d  = '0;
        hold_cnt_d = '0;
        rep_cnt_d  = '0;
        repeat_d   = 1'b0;
        stay_down  = level_q && level_d;

        if (differs && !deb_done) begin
            deb_cnt_d = (deb_cnt_q == DEB_MAX) ? deb_cnt_q : deb_cnt_q + DEB_W'(1);
        end

        // Only a cycle that starts and ends pressed may repeat, so no strobe collides with an edge.
        if (stay_down) begin
            hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);
            if (hold_cnt_q == HOLD_LAST) begin
                repeat_d = 1'b1;
            end
            if (hold_cnt_q == HOLD_MAX) begin
                rep_cnt_d = (rep_cnt_q == REP_LAST) ? '0 : rep_cnt_q + REP_W'(1);
                if (rep_cnt_q == REP_LAST) begin
                    repeat_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_65mhz) begin
        if (rst) begin
            deb_cnt_q  <= '0;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            repeat_q   <= 1'b0;
        end else begin
            deb_cnt_q  <= deb_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            repeat_q   <= repeat_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign repeat_o  = repeat_q;
    assign state_o   = state_q;

endmodule

// File: rtl/button_conditioner.sv
// Four independent conditioning channels for the up/down/next/set pushbuttons.
// Priority between simultaneous buttons is left to the downstream selector.
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic                clk_65mhz,
    input  logic                rst,
    button_conditioner_if.slave btn_if
);

    logic        level_w   [NUM_BTN];
    logic        press_w   [NUM_BTN];
    logic        release_w [NUM_BTN];
    logic        repeat_w  [NUM_BTN];
    chan_state_e state_w   [NUM_BTN];

    logic [NUM_BTN-1:0]   level_vec, press_vec, release_vec, repeat_vec;
    logic [2*NUM_BTN-1:0] state_vec;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_chan (
            .clk_65mhz (clk_65mhz),
            .rst       (rst),
            .raw_i     (btn_if.btn_raw[g]),
            .level_o   (level_w[g]),
            .press_o   (press_w[g]),
            .release_o (release_w[g]),
            .repeat_o  (repeat_w[g]),
            .state_o   (state_w[g])
        );
    end

    always_comb begin
        level_vec   = '0;
        press_vec   = '0;
        release_vec = '0;
        repeat_vec  = '0;
        state_vec   = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            level_vec[i]         = level_w[i];
            press_vec[i]         = press_w[i];
            release_vec[i]       = release_w[i];
            repeat_vec[i]        = repeat_w[i];
            state_vec[2*i +: 2]  = state_w[i];
        end
    end

    assign btn_if.btn_level   = level_vec;
    assign btn_if.btn_press   = press_vec;
    assign btn_if.btn_release = release_vec;
    assign btn_if.btn_repeat  = repeat_vec;
    assign btn_if.dbg_state   = state_vec;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed button scenarios plus random pin activity,
// scored every cycle against a sliding-window model of the debounce/repeat rules.
module tb_button_conditioner;
    import button_pkg::*;

    localparam int DEB  = 8;
    localparam int HOLD = 40;
    localparam int REP  = 10;

    logic       clk = 1'b0;
    logic       rst_drv;
    logic [3:0] raw_drv;
    int         cyc = -1;
    int         n_chk = 0;
    int         n_fail = 0;

    logic [15:0] exp_q[$];
    logic [3:0]  raw_h[$];
    bit          rst_h[$];
    int          press_at[4];

    int press_cnt[4];
    int rel_cnt[4];
    int rep_cnt[4];
    int last_press[4];
    int last_rel[4];
    int rep_e3[$];
    int pair_edge = -1;

    button_conditioner_if bi();
    assign bi.btn_raw = raw_drv;

    button_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk_65mhz (clk),
        .rst       (rst_drv),
        .btn_if    (bi)
    );

    always #8 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Value the second synchroniser flop presents at edge e.
    function automatic bit seen_at(int ch, int e);
        logic [3:0] v;
        if (e < 2) return 1'b0;
        if (rst_h[e-1] || rst_h[e-2]) return 1'b0;
        v = raw_h[e-2];
        return v[ch];
    endfunction

    // Reference: the level flips at edge e when the synchronised input disagreed with it
    // on every one of edges e-DEB..e with no reset inside that window; repeats fall at
    // HOLD, HOLD+REP, ... cycles after the press edge while the level stays high.
    initial begin : model
        logic [3:0] lvl, p, r, rp;
        int  e, age;
        bit  flip;
        lvl = '0;
        forever begin
            @(posedge clk);
            raw_h.push_back(raw_drv);
            rst_h.push_back(rst_drv);
            e   = raw_h.size() - 1;
            cyc = e;
            p = '0; r = '0; rp = '0;
            if (rst_drv) begin
                lvl = '0;
            end else begin
                for (int ch = 0; ch < 4; ch++) begin
                    flip = (e >= DEB + 2);
                    if (flip) begin
                        for (int k = e - DEB; k <= e; k++) begin
                            if (rst_h[k] || seen_at(ch, k) == lvl[ch]) flip = 1'b0;
                        end
                    end
                    if (flip) begin
                        lvl[ch] = ~lvl[ch];
                        if (lvl[ch]) begin
                            p[ch] = 1'b1;
                            press_at[ch] = e;
                        end else begin
                            r[ch] = 1'b1;
                        end
                    end else if (lvl[ch]) begin
                        age = e - press_at[ch];
                        if (age >= HOLD && (age - HOLD) % REP == 0) rp[ch] = 1'b1;
                    end
                end
            end
            exp_q.push_back({lvl, p, r, rp});
        end
    end

    initial begin : monitor
        logic [15:0] e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {bi.btn_level, bi.btn_press, bi.btn_release, bi.btn_repeat};
                n_chk++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs edge %0d: got lvl/prs/rel/rep=%h, required %h", cyc, a, e);
                end
                for (int ch = 0; ch < 4; ch++) begin
                    if (bi.btn_press[ch] === 1'b1) begin
                        press_cnt[ch]++;
                        last_press[ch] = cyc;
                    end
                    if (bi.btn_release[ch] === 1'b1) begin
                        rel_cnt[ch]++;
                        last_rel[ch] = cyc;
                    end
                    if (bi.btn_repeat[ch] === 1'b1) rep_cnt[ch]++;
                end
                if (bi.btn_repeat[BTN_SET] === 1'b1) rep_e3.push_back(cyc);
                if (bi.btn_press === 4'b0011) pair_edge = cyc;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : stim
        int t, tp, td, pc;
        rst_drv = 1'b1;
        raw_drv = '0;
        for (int i = 0; i < 4; i++) begin
            press_cnt[i] = 0; rel_cnt[i] = 0; rep_cnt[i] = 0;
            last_press[i] = -1; last_rel[i] = -1; press_at[i] = 0;
        end
        idle(4);
        chk("reset_fsm_state", int'(bi.dbg_state), 0);
        rst_drv = 1'b0;
        idle(5);

        // Clean press and release of UP.
        t = cyc + 1;
        raw_drv[BTN_UP] = 1'b1;
        idle(20);
        chk("up_press_edge", last_press[BTN_UP], t + 10);
        t = cyc + 1;
        raw_drv[BTN_UP] = 1'b0;
        idle(20);
        chk("up_release_edge", last_rel[BTN_UP], t + 10);
        chk("up_press_count", press_cnt[BTN_UP], 1);
        chk("up_no_repeat", rep_cnt[BTN_UP], 0);

        // NEXT bouncing every 3 cycles, then held.
        for (int i = 0; i < 30; i++) begin
            if (i % 3 == 0) raw_drv[BTN_NEXT] = ~raw_drv[BTN_NEXT];
            idle(1);
        end
        chk("next_quiet_while_bouncing", press_cnt[BTN_NEXT] + rel_cnt[BTN_NEXT], 0);
        t = cyc + 1;
        raw_drv[BTN_NEXT] = 1'b1;
        idle(20);
        chk("next_press_edge", last_press[BTN_NEXT], t + 10);
        chk("next_press_count", press_cnt[BTN_NEXT], 1);
        raw_drv[BTN_NEXT] = 1'b0;
        idle(20);

        // SET held 75 cycles past its press.
        rep_e3.delete();
        tp = cyc + 1;
        raw_drv[BTN_SET] = 1'b1;
        while (cyc < tp + 74) idle(1);
        raw_drv[BTN_SET] = 1'b0;
        idle(40);
        chk("set_repeat_count", rep_cnt[BTN_SET], 4);
        chk("set_first_repeat", (rep_e3.size() > 0) ? rep_e3[0] : -1, tp + 50);
        chk("set_last_repeat", (rep_e3.size() > 3) ? rep_e3[3] : -1, tp + 80);
        chk("set_release_edge", last_rel[BTN_SET], tp + 85);

        // UP and DOWN together.
        t = cyc + 1;
        raw_drv[1:0] = 2'b11;
        idle(20);
        chk("pair_press_edge", pair_edge, t + 10);
        raw_drv[1:0] = 2'b00;
        idle(20);

        // Reset 4 cycles into a debounce with the button still down.
        pc = press_cnt[BTN_UP];
        t = cyc + 1;
        raw_drv[BTN_UP] = 1'b1;
        idle(4);
        rst_drv = 1'b1;
        idle(3);
        rst_drv = 1'b0;
        td = cyc + 1;
        chk("rst_no_early_press", press_cnt[BTN_UP], pc);
        idle(20);
        chk("rst_fresh_press_edge", last_press[BTN_UP], td + 10);
        chk("rst_press_count", press_cnt[BTN_UP], pc + 1);
        raw_drv[BTN_UP] = 1'b0;
        idle(20);

        // Five-cycle glitch on DOWN.
        pc = press_cnt[BTN_DOWN] + rel_cnt[BTN_DOWN] + rep_cnt[BTN_DOWN];
        raw_drv[BTN_DOWN] = 1'b1;
        idle(5);
        raw_drv[BTN_DOWN] = 1'b0;
        idle(20);
        chk("glitch_no_activity", press_cnt[BTN_DOWN] + rel_cnt[BTN_DOWN] + rep_cnt[BTN_DOWN], pc);

        // Random pin activity with occasional resets.
        for (int it = 0; it < 60; it++) begin
            raw_drv = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) begin
                rst_drv = 1'b1;
                idle($urandom_range(1, 3));
                rst_drv = 1'b0;
            end
            idle($urandom_range(1, 70));
        end
        raw_drv = '0;
        idle(30);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
